// File: rtl/ctrl_pkg.sv
// ctrl_pkg
// Shared definitions for the multi-cycle control unit: the FSM state
// enumeration (its numeric values are what state_o shows on the debug port),
// the instruction-class enumeration produced by ctrl_decode, the opcode
// constants, and the alu_op / wb_sel / imm_sel output encodings.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXEC_R = 4'd2,
        EXEC_I = 4'd3,
        ADDR   = 4'd4,
        MEM_RD = 4'd5,
        WB_LD  = 4'd6,
        MEM_WR = 4'd7,
        BRANCH = 4'd8,
        LUI    = 4'd9,
        WB_ALU = 4'd10,
        HALT   = 4'd11
    } state_e;

    // Instruction class as seen by the FSM dispatch.
    typedef enum logic [2:0] {
        CLS_R     = 3'd0,
        CLS_I     = 3'd1,
        CLS_LOAD  = 3'd2,
        CLS_STORE = 3'd3,
        CLS_BEQ   = 3'd4,
        CLS_BNE   = 3'd5,
        CLS_LUI   = 3'd6,
        CLS_BAD   = 3'd7
    } op_class_e;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_BEQ   = 7'b1100011;
    localparam logic [6:0] OPC_BNE   = 7'b1100111;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;

    localparam logic [6:0] FUNCT7_SUB = 7'b0100000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] WBSEL_ALU = 2'b00;
    localparam logic [1:0] WBSEL_MEM = 2'b01;
    localparam logic [1:0] WBSEL_IMM = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_U = 2'b11;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode
// Purely combinational opcode / funct decode for the control unit.
// Ports:
//   opcode_i    [6:0]  instruction opcode field
//   funct3_i    [2:0]  instruction funct3 field
//   funct7_i    [6:0]  instruction funct7 field
//   op_class_o         instruction class used by the FSM dispatch
//   r_alu_op_o  [2:0]  ALU operation for an R-type instruction
//   r_legal_o          funct3 is one of the supported R-type operations
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output op_class_e  op_class_o,
    output logic [2:0] r_alu_op_o,
    output logic       r_legal_o
);

    // Map the opcode onto an instruction class; anything unknown is CLS_BAD.
    always_comb begin
        op_class_o = CLS_BAD;
        case (opcode_i)
            OPC_R:     op_class_o = CLS_R;
            OPC_I:     op_class_o = CLS_I;
            OPC_LOAD:  op_class_o = CLS_LOAD;
            OPC_STORE: op_class_o = CLS_STORE;
            OPC_BEQ:   op_class_o = CLS_BEQ;
            OPC_BNE:   op_class_o = CLS_BNE;
            OPC_LUI:   op_class_o = CLS_LUI;
            default:   op_class_o = CLS_BAD;
        endcase
    end

    // R-type ALU selection; funct7 only matters to split add from sub.
    always_comb begin
        r_alu_op_o = ALU_ADD;
        r_legal_o  = 1'b1;
        case (funct3_i)
            3'b000:  r_alu_op_o = (funct7_i == FUNCT7_SUB) ? ALU_SUB : ALU_ADD;
            3'b111:  r_alu_op_o = ALU_AND;
            3'b110:  r_alu_op_o = ALU_OR;
            3'b010:  r_alu_op_o = ALU_SLT;
            default: r_legal_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// control_unit
// Multi-cycle Moore control FSM with a data-memory wait counter.
// Parameter MEM_WAIT (1..7): cycles each data-memory access is held.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   opcode, funct3, funct7  instruction fields (sampled in DECODE/EXEC_R/ADDR)
//   zero                    ALU zero flag, used in BRANCH
//   pc_write, ir_write      PC and instruction-register load enables
//   mem_read, mem_write     data-memory strobes
//   reg_write               register-file write enable
//   alu_src_a, alu_src_b    ALU operand selects
//   alu_op, wb_sel, imm_sel ALU operation, write-back and immediate selects
//   state_o                 current state for debug
//   illegal                 sticky unsupported-instruction flag
module control_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 2
)
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] wb_sel,
    output logic [1:0] imm_sel,
    output logic [3:0] state_o,
    output logic       illegal
);

    localparam logic [2:0] WAIT_LOAD = 3'(MEM_WAIT - 1);

    state_e     state_q, state_d;
    logic [2:0] wait_q, wait_d;
    logic       illegal_q, illegal_d;
    logic       is_bne_q, is_bne_d;

    op_class_e  op_class;
    logic [2:0] r_alu_op;
    logic       r_legal;

    ctrl_decode u_decode (
        .opcode_i   (opcode),
        .funct3_i   (funct3),
        .funct7_i   (funct7),
        .op_class_o (op_class),
        .r_alu_op_o (r_alu_op),
        .r_legal_o  (r_legal)
    );

    // State, wait counter, sticky illegal flag and the branch flavour.
    // The branch flavour is captured in DECODE because opcode is not
    // allowed to influence anything once the FSM has reached BRANCH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= FETCH;
            wait_q    <= 3'd0;
            illegal_q <= 1'b0;
            is_bne_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            is_bne_q  <= is_bne_d;
        end
    end

    // Next-state and outputs. Every output defaults to 0 so each state only
    // names what it drives. While reset_n is low everything is forced to 0,
    // which also drops a memory strobe the instant reset arrives.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        illegal_d = illegal_q;
        is_bne_d  = is_bne_q;
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = 2'b00;
        alu_op    = ALU_ADD;
        wb_sel    = WBSEL_ALU;
        imm_sel   = IMM_I;

        case (state_q)
            FETCH: begin
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = 2'b01;
                state_d   = DECODE;
            end
            DECODE: begin
                is_bne_d = (op_class == CLS_BNE);
                case (op_class)
                    CLS_R:              state_d = EXEC_R;
                    CLS_I:              state_d = EXEC_I;
                    CLS_LOAD, CLS_STORE: state_d = ADDR;
                    CLS_BEQ, CLS_BNE:   state_d = BRANCH;
                    CLS_LUI:            state_d = LUI;
                    default: begin
                        state_d   = HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            EXEC_R: begin
                if (r_legal) begin
                    alu_op  = r_alu_op;
                    state_d = WB_ALU;
                end else begin
                    state_d   = HALT;
                    illegal_d = 1'b1;
                end
            end
            EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = WB_ALU;
            end
            WB_ALU: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                wait_d    = WAIT_LOAD;
                if (op_class == CLS_STORE) begin
                    imm_sel = IMM_S;
                    state_d = MEM_WR;
                end else begin
                    state_d = MEM_RD;
                end
            end
            MEM_RD: begin
                mem_read = 1'b1;
                if (wait_q == 3'd0) state_d = WB_LD;
                else                wait_d  = wait_q - 3'd1;
            end
            WB_LD: begin
                reg_write = 1'b1;
                wb_sel    = WBSEL_MEM;
                state_d   = FETCH;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                if (wait_q == 3'd0) state_d = FETCH;
                else                wait_d  = wait_q - 3'd1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                imm_sel   = IMM_B;
                pc_write  = is_bne_q ? ~zero : zero;
                state_d   = FETCH;
            end
            LUI: begin
                imm_sel   = IMM_U;
                reg_write = 1'b1;
                wb_sel    = WBSEL_IMM;
                state_d   = FETCH;
            end
            HALT: state_d = HALT;
            default: state_d = FETCH;
        endcase

        if (!reset_n) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            alu_src_a = 1'b0;
            alu_src_b = 2'b00;
            alu_op    = ALU_ADD;
            wb_sel    = WBSEL_ALU;
            imm_sel   = IMM_I;
        end
    end

    assign state_o = state_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit
// Self-checking bench for control_unit: directed instruction scenarios plus
// randomized instructions, each expanded by a reference model into the
// per-cycle list of states and control outputs the instruction should show.
module tb_control_unit;
    import ctrl_pkg::*;

    localparam int MEM_WAIT = 2;

    localparam logic [6:0] opR     = 7'b0110011;
    localparam logic [6:0] opImm   = 7'b0010011;
    localparam logic [6:0] opLoad  = 7'b0000011;
    localparam logic [6:0] opStore = 7'b0100011;
    localparam logic [6:0] opBeq   = 7'b1100011;
    localparam logic [6:0] opBne   = 7'b1100111;
    localparam logic [6:0] opLui   = 7'b0110111;

    localparam logic [2:0] aluAdd = 3'b000;
    localparam logic [2:0] aluSub = 3'b001;
    localparam logic [2:0] aluAnd = 3'b010;
    localparam logic [2:0] aluOr  = 3'b011;
    localparam logic [2:0] aluSlt = 3'b100;

    logic       clk;
    logic       reset_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       zero;
    logic       pc_write, ir_write, mem_read, mem_write, reg_write, alu_src_a;
    logic [1:0] alu_src_b, wb_sel, imm_sel;
    logic [2:0] alu_op;
    logic [3:0] state_o;
    logic       illegal;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [19:0] expQ[$];

    control_unit #(.MEM_WAIT(MEM_WAIT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7    (funct7),
        .zero      (zero),
        .pc_write  (pc_write),
        .ir_write  (ir_write),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .reg_write (reg_write),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .wb_sel    (wb_sel),
        .imm_sel   (imm_sel),
        .state_o   (state_o),
        .illegal   (illegal)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One expected cycle: {state, illegal, pc, ir, mrd, mwr, rw, srcA, srcB, aluOp, wbSel, immSel}.
    function automatic logic [19:0] rec(state_e st, bit ill, bit pcw, bit irw, bit mr, bit mw,
                                        bit rw, bit asa, logic [1:0] asb, logic [2:0] aop,
                                        logic [1:0] wb, logic [1:0] imm);
        return {st, ill, pcw, irw, mr, mw, rw, asa, asb, aop, wb, imm};
    endfunction

    function automatic logic [19:0] observed();
        return {state_o, illegal, pc_write, ir_write, mem_read, mem_write, reg_write,
                alu_src_a, alu_src_b, alu_op, wb_sel, imm_sel};
    endfunction

    task automatic checkOutput(input string tag, input logic [19:0] obs, input logic [19:0] expv);
        testsRun++;
        if (obs !== expv) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%05h expected 0x%05h", tag, obs, expv);
        end
    endtask

    // Reference model: lists the cycles an instruction occupies from the
    // latency and output rules, ending in haltCycles HALT cycles if illegal.
    task automatic buildExpected(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                 input bit z, input int haltCycles);
        logic [2:0] aop;
        bit legal;
        expQ.delete();
        expQ.push_back(rec(FETCH, 0, 1, 1, 0, 0, 0, 0, 2'b01, aluAdd, 2'b00, 2'b00));
        expQ.push_back(rec(DECODE, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00));
        case (op)
            opR: begin
                legal = 1'b1;
                aop   = aluAdd;
                case (f3)
                    3'b000:  aop = (f7 == 7'b0100000) ? aluSub : aluAdd;
                    3'b111:  aop = aluAnd;
                    3'b110:  aop = aluOr;
                    3'b010:  aop = aluSlt;
                    default: legal = 1'b0;
                endcase
                if (legal) begin
                    expQ.push_back(rec(EXEC_R, 0, 0, 0, 0, 0, 0, 0, 2'b00, aop, 2'b00, 2'b00));
                    expQ.push_back(rec(WB_ALU, 0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b000, 2'b00, 2'b00));
                end else begin
                    expQ.push_back(rec(EXEC_R, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00));
                    repeat (haltCycles)
                        expQ.push_back(rec(HALT, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00));
                end
            end
            opImm: begin
                expQ.push_back(rec(EXEC_I, 0, 0, 0, 0, 0, 0, 1, 2'b10, aluAdd, 2'b00, 2'b00));
                expQ.push_back(rec(WB_ALU, 0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b000, 2'b00, 2'b00));
            end
            opLoad: begin
                expQ.push_back(rec(ADDR, 0, 0, 0, 0, 0, 0, 1, 2'b10, aluAdd, 2'b00, 2'b00));
                repeat (MEM_WAIT)
                    expQ.push_back(rec(MEM_RD, 0, 0, 0, 1, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00));
                expQ.push_back(rec(WB_LD, 0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b000, 2'b01, 2'b00));
            end
            opStore: begin
                expQ.push_back(rec(ADDR, 0, 0, 0, 0, 0, 0, 1, 2'b10, aluAdd, 2'b00, 2'b01));
                repeat (MEM_WAIT)
                    expQ.push_back(rec(MEM_WR, 0, 0, 0, 0, 1, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00));
            end
            opBeq, opBne: begin
                bit taken = (op == opBeq) ? z : !z;
                expQ.push_back(rec(BRANCH, 0, taken, 0, 0, 0, 0, 1, 2'b00, aluSub, 2'b00, 2'b10));
            end
            opLui: begin
                expQ.push_back(rec(LUI, 0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b000, 2'b10, 2'b11));
            end
            default: begin
                repeat (haltCycles)
                    expQ.push_back(rec(HALT, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00));
            end
        endcase
    endtask

    // Asynchronous reset pulse starting mid-cycle; released 1 time unit after
    // a rising edge so the next rising edge performs the FETCH.
    task automatic resetPulse(input string tag);
        reset_n = 1'b0;
        #1;
        checkOutput({tag, "_inRst"}, observed(),
                    rec(FETCH, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        checkOutput({tag, "_afterRst"}, observed(),
                    rec(FETCH, 0, 1, 1, 0, 0, 0, 0, 2'b01, aluAdd, 2'b00, 2'b00));
    endtask

    // Runs one instruction cycle by cycle. The true fields are presented only
    // where the design may sample them; elsewhere they are scrambled. If
    // abortAt matches a cycle index, reset is pulsed after that cycle's check.
    task automatic applyStimulus(input string name, input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input bit z, input int haltCycles,
                                 input int abortAt);
        logic [19:0] e;
        state_e st;
        int idx = 0;
        buildExpected(op, f3, f7, z, haltCycles);
        while (expQ.size() > 0) begin
            e  = expQ.pop_front();
            st = state_e'(e[19:16]);
            if (st == DECODE || st == EXEC_R || st == ADDR) begin
                opcode = op;
                funct3 = f3;
                funct7 = f7;
            end else begin
                opcode = 7'($urandom);
                funct3 = 3'($urandom);
                funct7 = 7'($urandom);
            end
            zero = (st == BRANCH) ? z : 1'($urandom);
            @(negedge clk);
            checkOutput($sformatf("%s_c%0d", name, idx), observed(), e);
            if (idx == abortAt) begin
                #1;
                resetPulse({name, "_abort"});
                expQ.delete();
                return;
            end
            @(posedge clk);
            #1;
            idx++;
        end
        if (state_e'(e[19:16]) == HALT) resetPulse({name, "_halt"});
    endtask

    initial begin
        logic [6:0] rop;
        logic [6:0] opTab [7];
        opTab[0] = opR;   opTab[1] = opImm; opTab[2] = opLoad; opTab[3] = opStore;
        opTab[4] = opBeq; opTab[5] = opBne; opTab[6] = opLui;

        reset_n = 1'b0;
        opcode  = 7'd0;
        funct3  = 3'd0;
        funct7  = 7'd0;
        zero    = 1'b0;
        #2;
        resetPulse("init");

        applyStimulus("addi",     opImm,   3'b000, 7'b0000000, 0, 0, -1);
        applyStimulus("ld",       opLoad,  3'b011, 7'b0000000, 0, 0, -1);
        applyStimulus("sd",       opStore, 3'b011, 7'b0000000, 0, 0, -1);
        applyStimulus("beq_z1",   opBeq,   3'b000, 7'b0000000, 1, 0, -1);
        applyStimulus("beq_z0",   opBeq,   3'b000, 7'b0000000, 0, 0, -1);
        applyStimulus("bne_z0",   opBne,   3'b001, 7'b0000000, 0, 0, -1);
        applyStimulus("bne_z1",   opBne,   3'b001, 7'b0000000, 1, 0, -1);
        applyStimulus("lui",      opLui,   3'b101, 7'b1010101, 0, 0, -1);
        applyStimulus("r_sub",    opR,     3'b000, 7'b0100000, 0, 0, -1);
        applyStimulus("r_add",    opR,     3'b000, 7'b0000000, 0, 0, -1);
        applyStimulus("r_slt",    opR,     3'b010, 7'b0000000, 0, 0, -1);
        applyStimulus("r_and",    opR,     3'b111, 7'b0000000, 0, 0, -1);
        applyStimulus("r_or",     opR,     3'b110, 7'b0000000, 0, 0, -1);
        applyStimulus("r_bad",    opR,     3'b001, 7'b0000000, 0, 3, -1);
        applyStimulus("bad_op",   7'b1111111, 3'b000, 7'b0000000, 0, 10, -1);
        applyStimulus("sd_abort", opStore, 3'b000, 7'b0000000, 0, 0, 4);
        applyStimulus("after_ab", opImm,   3'b000, 7'b0000000, 0, 0, -1);

        for (int n = 0; n < 80; n++) begin
            int sel = $urandom_range(0, 7);
            rop = (sel < 7) ? opTab[sel] : 7'($urandom);
            applyStimulus($sformatf("rnd%0d", n), rop, 3'($urandom),
                          ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'($urandom),
                          1'($urandom), 3, -1);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have parameter MEM_WAIT, default 2, meaning the number of wait cycles per data-memory access (1..7).
REQ-002 The block SHALL have ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- opcode  in  7  instruction bits [6:0] from the instruction register.
- funct3  in  3  instruction bits [14:12].
- funct7  in  7  instruction bits [31:25].
- zero  in  1  ALU result-equals-zero flag.
- pc_write  out  1  PC load enable.
- ir_write  out  1  instruction register load enable.
- mem_read  out  1  data-memory read strobe.
- mem_write  out  1  data-memory write strobe.
- reg_write  out  1  register-file write enable.
- alu_src_a  out  1  0 = PC, 1 = rs1.
- alu_src_b  out  2  00 = rs2, 01 = constant 4, 10 = immediate.
- alu_op  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt.
- wb_sel  out  2  00 = ALU, 01 = memory, 10 = immediate.
- imm_sel  out  2  00 = I, 01 = S, 10 = B, 11 = U; this configures the immediate generator.
- state_o  out  4  current state encoding, for debug.
- illegal  out  1  sticky flag for an unsupported opcode.

Function
REQ-003 The block SHALL be a Moore FSM with states FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, WB_LD, MEM_WR, BRANCH, LUI, WB_ALU, HALT.
REQ-004 FETCH SHALL assert ir_write=1, pc_write=1, alu_src_a=0, alu_src_b=01, alu_op=000, then go to DECODE.
REQ-005 DECODE SHALL dispatch on opcode:
- 0110011 -> EXEC_R.
- 0010011 -> EXEC_I.
- 0000011 and 0100011 -> ADDR.
- 1100011 and 1100111 -> BRANCH.
- 0110111 -> LUI.
- any other opcode -> HALT, with illegal set to 1.
REQ-006 EXEC_R SHALL select alu_op as follows: funct3=000 with funct7=0100000 -> sub; funct3=000 otherwise -> add; funct3=111 -> and; funct3=110 -> or; funct3=010 -> slt. Any other funct3 SHALL go to HALT with illegal set.
REQ-007 EXEC_I SHALL drive alu_src_a=1, alu_src_b=10, imm_sel=00, alu_op=000; EXEC_R and EXEC_I SHALL both go to WB_ALU.
REQ-008 WB_ALU SHALL assert reg_write=1 with wb_sel=00, then go to FETCH.
REQ-009 ADDR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=000, with imm_sel=00 for a load and 01 for a store; next state is MEM_RD for a load, MEM_WR for a store.
REQ-010 MEM_RD and MEM_WR SHALL hold mem_read and mem_write respectively for exactly MEM_WAIT cycles, timed by a 3-bit wait counter that loads MEM_WAIT-1 on entry and exits when it reaches 0.
REQ-011 MEM_RD SHALL be followed by WB_LD, which asserts reg_write=1 with wb_sel=01; MEM_WR SHALL return to FETCH.
REQ-012 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=001, imm_sel=10. It SHALL assert pc_write for one cycle when (opcode=1100011 and zero=1) or (opcode=1100111 and zero=0), then go to FETCH.
REQ-013 LUI SHALL drive imm_sel=11 and assert reg_write=1 with wb_sel=10, then go to FETCH.
REQ-014 HALT SHALL be absorbing and drive all enables and strobes to 0; only reset_n leaves it.
REQ-015 Outputs not named for a state SHALL be 0 in that state; this rule SHALL have no exceptions.
REQ-016 Instruction latencies in cycles SHALL be: R/I = 4, LUI = 3, branch = 3, ld = 4+MEM_WAIT, sd = 3+MEM_WAIT.
REQ-017 opcode, funct3 and funct7 SHALL be sampled only in DECODE, EXEC_R and ADDR; changes in any other state SHALL have no effect.

Reset
REQ-018 While reset_n=0 the state SHALL be FETCH and the wait counter, illegal and all enables/strobes SHALL be 0; this SHALL be asynchronous.
REQ-019 Reset asserted mid-access (MEM_RD/MEM_WR) SHALL drop the memory strobes immediately and restart in FETCH.
REQ-020 Deassertion of reset_n SHALL be followed by a FETCH cycle on the first rising edge.

Structure
REQ-021 A shared package ctrl_pkg SHALL hold the state enum, the opcode constants, and the alu_op, wb_sel and imm_sel encodings.
REQ-022 The combinational opcode/funct decode SHALL be one sub-module, ctrl_decode; the FSM and wait counter SHALL stay in control_unit.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- addi (opcode 0010011) -> states FETCH, DECODE, EXEC_I, WB_ALU; reg_write=1 only in cycle 4.
- ld with MEM_WAIT=2 -> mem_read=1 for exactly 2 cycles, then WB_LD with wb_sel=01; total 6 cycles.
- beq with zero=1 -> pc_write=1 in BRANCH; beq with zero=0 -> pc_write=0; bne (1100111) with zero=0 -> pc_write=1.
- R-type funct3=000 with funct7=0100000 -> alu_op=001; funct3=010 -> alu_op=100; funct3=001 -> HALT with illegal=1.
- opcode 1111111 -> HALT with illegal=1 and all strobes 0 for 10 cycles; reset_n pulse -> illegal=0, FETCH.
- reset_n=0 during the 2nd MEM_WR cycle -> mem_write=0 before the next edge; after release, state_o=FETCH.
